imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Byte-stream boot loader upstream of the multicycle RISC-V core.
- Receives a program image over a valid/ready byte channel and assembles it into 32-bit little-endian words.
- Writes each word into the instruction memory write port (waddress/Datain/Wr) and holds the core in reset until the image is fully loaded.
- Releases the core, which then fetches from BASE_ADDR.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- MAX_WORDS, 16384, largest accepted word count; larger headers are rejected.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte; a byte transfers when in_valid && in_ready at a rising clk edge
- imem_wr  output  1  one-cycle instruction-memory write strobe
- imem_waddress  output  32  write byte address
- imem_datain  output  32  write data
- cpu_reset  output  1  drives the core's reset; high while loading or on error
- done  output  1  image loaded and core released
- error  output  1  load rejected; sticky until reset
- words_loaded  output  16  count of words written so far

Behaviour:
- Reset is asynchronous and active-high. All outputs take these values while reset is high and immediately after it:
  - in_ready=0
  - imem_wr=0, imem_waddress=BASE_ADDR, imem_datain=0
  - cpu_reset=1, done=0, error=0, words_loaded=0
  - State = HDR0
- in_ready is registered: it goes to 1 on the first clock after reset deasserts and stays 1 in HDR0, HDR1, DATA (and CSUM when compiled in).
- Stream format: count N as 2 bytes, little-endian (low byte first), followed by 4*N image bytes, little-endian within each word.
- HDR0: accept byte into N[7:0] -> HDR1.
- HDR1: accept byte into N[15:8], then:
  - N > MAX_WORDS -> ERROR.
  - N == 0 -> DONE (or CSUM when compiled in).
  - Otherwise -> DATA, with byte index b=0 and word index k=0.
- DATA: each accepted byte goes into word[8*b+7 : 8*b], then b increments. On accepting the byte with b==3:
  - The next cycle drives imem_wr=1, imem_datain=assembled word, imem_waddress=BASE_ADDR+4*k.
  - words_loaded increments in that same cycle; k increments and b returns to 0.
- Write latency: exactly 1 cycle from the 4th byte's acceptance edge to the imem_wr-high cycle. imem_wr is never high for two consecutive cycles.
- Back-to-back bytes at one per cycle are sustained; the memory needs no backpressure.
- Address arithmetic is 32-bit modulo 2^32; wrap-around is not flagged.
- After the write of word N-1 (the imem_wr cycle) -> DONE on the next edge (or CSUM when compiled in).
- DONE:
  - in_ready=0, cpu_reset=0, done=1.
  - The state is held until reset; further in_valid is ignored.
  - cpu_reset falls on the cycle after the last imem_wr, so the core never observes a partially written image.
- ERROR:
  - in_ready=0, cpu_reset=1, error=1, done=0; held until reset.
- in_valid low stalls any state indefinitely with no timeout; partial-word bytes are retained.
- Reset asserted mid-load: the load aborts immediately, any pending imem_wr is suppressed, and the outputs return to reset values. Already-written memory contents are not cleared.
- imem_waddress and imem_datain hold their last written values when imem_wr=0.

Optional Feature:
- Macro: IMEM_BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - One extra byte follows the image: the XOR of all preceding stream bytes, header included.
  - State CSUM is entered after the last write, or after HDR1 when N==0.
  - On accepting the byte: match -> DONE; mismatch -> ERROR.
  - cpu_reset stays high until the checksum verifies.
- Undefined:
  - No CSUM state and no checksum byte is consumed.
  - error asserts only for N > MAX_WORDS.

Test Plan:
- Stream 02 00 13 05 A0 00 93 05 50 00, one byte per cycle -> two writes, each 1 cycle after its 4th byte:
  - 0x00A00513 @ 0x0
  - 0x00500593 @ 0x4
  - Then words_loaded=2, done=1, and cpu_reset falls on the cycle after the second imem_wr.
- Same stream with in_valid randomly deasserted (50%) -> identical write sequence and values; no extra imem_wr.
- Header 00 00 -> no imem_wr, done=1 two cycles after the second byte; checksum build: the checksum byte 00 is required first.
- Header N=MAX_WORDS+1 (0x01 0x40 with default) -> error=1, cpu_reset=1, in_ready=0, no writes.
- Reset asserted after 6 image bytes of an N=3 load -> outputs return to reset values at once. A fresh full stream then loads correctly from BASE_ADDR.
- Checksum build: correct XOR byte -> done=1; corrupted checksum byte -> error=1 and cpu_reset remains 1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles a counted little-endian image into 32-bit words and holds the core in reset until it is loaded.
// Latency: 1 cycle from the 4th byte of a word to its imem_wr strobe; done/cpu_reset release 1 cycle after the last write.
// Backpressure: in_ready is registered and drops only once the image is complete or rejected; the memory port never stalls.
// Optional IMEM_BOOT_LOADER_CHECKSUM_EN: a trailing XOR byte must match before the core is released.
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_wr,
    output logic [31:0] imem_waddress,
    output logic [31:0] imem_datain,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {HDR0, HDR1, DATA, FIN, CSUM, DONE, ERROR} state_t;

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [1:0]  b_q, b_d;
    logic [23:0] word_q, word_d;
    logic        in_ready_q, in_ready_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] dat_q, dat_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] words_q, words_d;
    logic        accept;
    logic [15:0] hdr_n;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    assign accept = in_valid && in_ready_q;
    assign hdr_n  = {in_data, n_q[7:0]};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        b_d     = b_q;
        word_d  = word_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        dat_d   = dat_q;
        words_d = words_q;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        if (accept && (state_q == HDR0 || state_q == HDR1 || state_q == DATA))
            csum_d = csum_q ^ in_data;
`endif
        case (state_q)
            HDR0: if (accept) begin
                n_d[7:0] = in_data;
                state_d  = HDR1;
            end
            HDR1: if (accept) begin
                n_d[15:8] = in_data;
                b_d       = 2'd0;
                if (32'(hdr_n) > 32'(MAX_WORDS)) state_d = ERROR;
                else if (hdr_n == 16'd0)         state_d = FIN;
                else                             state_d = DATA;
            end
            DATA: if (accept) begin
                b_d = b_q + 2'd1;
                case (b_q)
                    2'd0: word_d[7:0]   = in_data;
                    2'd1: word_d[15:8]  = in_data;
                    2'd2: word_d[23:16] = in_data;
                    default: begin
                        wr_d    = 1'b1;
                        dat_d   = {in_data, word_q};
                        addr_d  = BASE_ADDR + {14'b0, words_q, 2'b00};
                        words_d = words_q + 16'd1;
                        if (words_q + 16'd1 == n_q) state_d = FIN;
                    end
                endcase
            end
            // One settling cycle after the final write so release never overlaps it.
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            FIN:  state_d = CSUM;
            CSUM: if (accept) state_d = (in_data == csum_q) ? DONE : ERROR;
`else
            FIN:  state_d = DONE;
`endif
            default: state_d = state_q;
        endcase

        in_ready_d  = (state_d == HDR0) || (state_d == HDR1) || (state_d == DATA)
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                      || (state_d == CSUM)
`endif
                      ;
        done_d      = (state_d == DONE);
        error_d     = (state_d == ERROR);
        cpu_reset_d = (state_d != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HDR0;
            n_q         <= 16'd0;
            b_q         <= 2'd0;
            word_q      <= 24'd0;
            in_ready_q  <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= BASE_ADDR;
            dat_q       <= 32'd0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= 16'd0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            b_q         <= b_d;
            word_q      <= word_d;
            in_ready_q  <= in_ready_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            dat_q       <= dat_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
            words_q     <= words_d;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign in_ready      = in_ready_q;
    assign imem_wr       = wr_q;
    assign imem_waddress = addr_q;
    assign imem_datain   = dat_q;
    assign cpu_reset     = cpu_reset_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_loaded  = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: drives counted byte streams and scoreboards every imem_wr (address, data, cycle).
module tb_imem_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 16384;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, imem_wr, cpu_reset, done, error;
    logic [31:0] imem_waddress, imem_datain;
    logic [15:0] words_loaded;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] img[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    bit          prev_wr = 1'b0;

    localparam logic [83:0] RST_VAL = {1'b0, 1'b0, BASE, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0};

    imem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_wr(imem_wr), .imem_waddress(imem_waddress),
        .imem_datain(imem_datain), .cpu_reset(cpu_reset), .done(done),
        .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write must match the next expected entry, including its cycle.
    always @(negedge clk) begin
        if (!reset && imem_wr) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_wr addr=%h data=%h (no write expected)", imem_waddress, imem_datain);
            end else begin
                mon_e = exp_q.pop_front();
                if (imem_waddress !== mon_e.addr || imem_datain !== mon_e.data || 32'(cyc) !== mon_e.cyc) begin
                    mismatched++;
                    $display("FAIL wr got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                             imem_waddress, imem_datain, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
            compared++;
            if (prev_wr) begin
                mismatched++;
                $display("FAIL wr_consecutive imem_wr high two cycles in a row, want single-cycle strobe");
            end
        end
        prev_wr = imem_wr && !reset;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    // Entered and left at a negedge; in_valid is left high for back-to-back streaming.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit push,
                             input logic [31:0] a, input logic [31:0] d);
        int n;
        if (gaps)
            for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (!in_ready) begin
            mismatched++;
            $display("FAIL ready_timeout in_ready=%b, want 1 within 100 cycles", in_ready);
        end else begin
            if (push) exp_q.push_back({a, d, 32'(cyc + 1)});
            @(negedge clk);
        end
    endtask

    task automatic load(input logic [15:0] n, input int nimg, input bit gaps, input bit bad_csum);
        logic [7:0]  x, by;
        logic [31:0] w;
        x = n[7:0] ^ n[15:8];
        send_byte(n[7:0], gaps, 1'b0, 32'h0, 32'h0);
        send_byte(n[15:8], gaps, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < nimg; i++) begin
            w  = img[i / 4];
            by = w[8 * (i % 4) +: 8];
            x  = x ^ by;
            send_byte(by, gaps, (i % 4) == 3, BASE + 32'(4 * (i / 4)), w);
        end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        if (nimg == 4 * int'(n)) send_byte(bad_csum ? ~x : x, gaps, 1'b0, 32'h0, 32'h0);
`else
        if (bad_csum) x = ~x;
`endif
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_drained(input string name);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_missing_wr pending=%0d, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if ({in_ready, imem_wr, imem_waddress, imem_datain, cpu_reset, done, error, words_loaded} !== RST_VAL) begin
            mismatched++;
            $display("FAIL reset_values got %h, want %h",
                     {in_ready, imem_wr, imem_waddress, imem_datain, cpu_reset, done, error, words_loaded}, RST_VAL);
        end
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if ({in_ready, cpu_reset, done, error} !== 4'b1100) begin
            mismatched++;
            $display("FAIL ready_after_reset got rdy/cpu_rst/done/err=%b, want 1100", {in_ready, cpu_reset, done, error});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        img = '{32'h00A00513, 32'h00500593};
        load(16'd2, 8, 1'b0, 1'b0);
`ifndef IMEM_BOOT_LOADER_CHECKSUM_EN
        compared++;
        if ({cpu_reset, done} !== 2'b10) begin
            mismatched++;
            $display("FAIL b2b_last_wr_cycle cpu_reset/done=%b, want 10", {cpu_reset, done});
        end
        @(negedge clk);
`endif
        compared++;
        if ({cpu_reset, done, error, in_ready, words_loaded} !== {4'b0100, 16'd2}) begin
            mismatched++;
            $display("FAIL b2b_release cpu_reset/done/err/rdy=%b words=%0d, want 0100 words=2",
                     {cpu_reset, done, error, in_ready}, words_loaded);
        end
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        compared++;
        if ({done, words_loaded} !== {1'b1, 16'd2}) begin
            mismatched++;
            $display("FAIL done_hold done=%b words=%0d, want 1 words=2", done, words_loaded);
        end
        check_drained("b2b");
    endtask

    task automatic test_gaps();
        do_reset();
        img = '{32'h00A00513, 32'h00500593};
        load(16'd2, 8, 1'b1, 1'b0);
        for (int i = 0; i < 20 && !(done || error); i++) @(negedge clk);
        compared++;
        if ({done, error, cpu_reset, words_loaded} !== {3'b100, 16'd2}) begin
            mismatched++;
            $display("FAIL gaps_done done/err/cpu_rst=%b words=%0d, want 100 words=2",
                     {done, error, cpu_reset}, words_loaded);
        end
        check_drained("gaps");
    endtask

    task automatic test_zero();
        do_reset();
        send_byte(8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
        send_byte(8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
        in_valid = 1'b0;
        compared++;
        if ({done, in_ready, cpu_reset} !== 3'b001) begin
            mismatched++;
            $display("FAIL zero_first_cycle done/rdy/cpu_rst=%b, want 001", {done, in_ready, cpu_reset});
        end
        @(negedge clk);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        repeat (3) @(negedge clk);
        compared++;
        if ({done, in_ready, cpu_reset} !== 3'b011) begin
            mismatched++;
            $display("FAIL zero_wait_csum done/rdy/cpu_rst=%b, want 011", {done, in_ready, cpu_reset});
        end
        send_byte(8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
        in_valid = 1'b0;
`endif
        compared++;
        if ({done, cpu_reset, error, words_loaded} !== {3'b100, 16'd0}) begin
            mismatched++;
            $display("FAIL zero_done done/cpu_rst/err=%b words=%0d, want 100 words=0",
                     {done, cpu_reset, error}, words_loaded);
        end
        check_drained("zero");
    endtask

    task automatic test_overflow();
        do_reset();
        load(16'(MAXW + 1), 0, 1'b0, 1'b0);
        compared++;
        if ({error, cpu_reset, in_ready, done, words_loaded} !== {4'b1100, 16'd0}) begin
            mismatched++;
            $display("FAIL overflow err/cpu_rst/rdy/done=%b words=%0d, want 1100 words=0",
                     {error, cpu_reset, in_ready, done}, words_loaded);
        end
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        compared++;
        if ({error, in_ready} !== 2'b10) begin
            mismatched++;
            $display("FAIL overflow_hold err/rdy=%b, want 10", {error, in_ready});
        end
        do_reset();
        load(16'(MAXW), 0, 1'b0, 1'b0);
        @(negedge clk);
        compared++;
        if ({error, in_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL max_words_accepted err/rdy=%b, want 01", {error, in_ready});
        end
    endtask

    task automatic test_abort();
        do_reset();
        img = '{32'h11223344, 32'hA5A55A5A, 32'hDEADBEEF};
        load(16'd3, 6, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        compared++;
        if ({in_ready, imem_wr, imem_waddress, imem_datain, cpu_reset, done, error, words_loaded} !== RST_VAL) begin
            mismatched++;
            $display("FAIL abort_reset got %h, want %h",
                     {in_ready, imem_wr, imem_waddress, imem_datain, cpu_reset, done, error, words_loaded}, RST_VAL);
        end
        check_drained("abort_partial");
        @(negedge clk);
        reset = 1'b0;
        load(16'd3, 12, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !(done || error); i++) @(negedge clk);
        compared++;
        if ({done, error, words_loaded} !== {2'b10, 16'd3}) begin
            mismatched++;
            $display("FAIL abort_reload done/err=%b words=%0d, want 10 words=3", {done, error}, words_loaded);
        end
        check_drained("abort_reload");
    endtask

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        do_reset();
        img = '{32'h00A00513, 32'h00500593};
        load(16'd2, 8, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        compared++;
        if ({error, cpu_reset, done, in_ready} !== 4'b1100) begin
            mismatched++;
            $display("FAIL csum_bad err/cpu_rst/done/rdy=%b, want 1100", {error, cpu_reset, done, in_ready});
        end
        check_drained("csum_bad");
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_zero();
        test_overflow();
        test_abort();
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
